uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  8N1 UART transmitter; the transmit-side counterpart of the uart receive path.
//  Accepts bytes via valid/ready, buffers them in a small FIFO, serialises LSB-first on txd.
//  Timed by the 16x-oversample 'baud' level from baud_rate_generation (same one feeding uart).
//  Sits beside uart on sysclk; txd loops back to rxd for bench checks.
// PARAMETERS
//  DATA_BITS   8   payload bits per frame
//  OVERSAMPLE  16  baud rising edges per bit period
//  FIFO_DEPTH  4   buffered bytes (power of 2), excluding byte in shifter
//  CNT_W       3   width of fifo_count, = clog2(FIFO_DEPTH)+1
// PORTS
//  sysclk      in   1          system clock; all logic on posedge
//  reset       in   1          synchronous, active-high
//  baud        in   1          16x bit-rate level signal; rising edge detected in sysclk domain
//  tx_data     in   DATA_BITS  byte to send
//  tx_valid    in   1          tx_data valid
//  tx_ready    out  1          FIFO can accept; transfer when tx_valid & tx_ready at posedge
//  txd         out  1          serial out, idle high
//  tx_busy     out  1          frame in progress (START..STOP)
//  fifo_count  out  CNT_W      bytes waiting in FIFO (0..FIFO_DEPTH)
// BEHAVIOUR
//  - Reset: txd=1, tx_ready=1, tx_busy=0, fifo_count=0, FSM=IDLE, FIFO pointers cleared.
//    Edge-detect reg loads current baud during reset: no false tick on release.
//  - tick = baud & ~baud_q (one sysclk pulse per baud rising edge).
//  - tx_ready = (fifo_count != FIFO_DEPTH); registered-equivalent, no full bypass.
//  - Push & pop same cycle: count unchanged; push when full is impossible (ready=0).
//  - FSM: IDLE, START, DATA, STOP. Registered txd.
//    IDLE: txd=1. On tick with fifo_count!=0: pop into shifter, -> START, sub=0.
//    START: txd=0 for OVERSAMPLE ticks -> DATA, bit=0.
//    DATA: txd=shift[0]; after OVERSAMPLE ticks shift right; after DATA_BITS bits -> STOP.
//    STOP: txd=1 for OVERSAMPLE ticks; at last tick: if fifo non-empty pop, -> START
//      (back-to-back, no idle gap); else -> IDLE.
//  - Latency: txd falls on the cycle after the first tick seen with data queued;
//    one bit = OVERSAMPLE ticks (9600 Bd: 104166.667 ns).
//  - tx_busy high in START/DATA/STOP; low in IDLE.
//  - Sub-bit counter 4 bits, bit counter 3 bits; both wrap to 0 on state change.
//  - Reset mid-frame: next cycle txd=1, FIFO flushed, frame dropped; no partial resend.
//  - tx_valid during reset ignored. tx_data held stable only on handshake cycle.
// STRUCTURE
//  - Shared header uart_defs.vh: DATA_BITS, OVERSAMPLE, FSM state encodings
//    (shared with receiver).
//  - Sub-module uart_tx_fifo: sync FIFO, push/pop/full/empty/count, wrap-around pointers.
//  - Top: edge detect, FSM, counters, shifter.
// TESTING (sysclk 100 MHz, baud_rate_generation at 16x9600)
//  1. Reset held, released, no stimulus 2 ms -> txd=1, tx_ready=1, tx_busy=0, fifo_count=0.
//  2. Push 0xE9 -> txd 0,1,0,0,1,0,1,1,1,1, each 104166.667 ns +-1 tick;
//     tx_busy falls after stop.
//  3. Hold tx_valid, push 0x00,0xFF,0x55,0xAA,0xE9 -> ready low at count=4;
//     5th accepted after first pop; five contiguous frames, no idle gap.
//  4. Push with count=1 on the pop cycle -> count stays 1, no byte lost or duplicated.
//  5. Reset asserted during DATA bit 3 -> txd=1 next cycle, count=0,
//     no further frames after release.
//  6. Loopback txd->uart rxd, send 0xE9 three times -> receiver outputs 0xE9 x3,
//     no framing error.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: frame geometry, FIFO sizing and transmitter FSM states
package uart_tx_buffered_pkg;
    localparam int DATA_BITS = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// uart_tx_buffered_fifo: synchronous FIFO with wrap-around pointers and occupancy count
module uart_tx_buffered_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge sysclk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with input FIFO, timed by a 16x baud level
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
(
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic [CNT_W-1:0]     fifo_count
);
    tx_state_t state, state_n;
    logic baud_q, tick, last, pop, push, full, empty, txd_n;
    logic [3:0] sub, sub_n;
    logic [2:0] bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n, fifo_dout;
    assign tick     = baud & ~baud_q;
    assign last     = sub == 4'(OVERSAMPLE - 1);
    assign tx_ready = ~full;
    assign push     = tx_valid & tx_ready;
    assign tx_busy  = state != IDLE;
    uart_tx_buffered_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) fifo (
        .sysclk(sysclk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(tx_data),
        .dout(fifo_dout),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    // baud_q tracks baud even in reset so release never sees a stale rising edge
    always_ff @(posedge sysclk) begin
        baud_q <= baud;
        if (reset) begin
            state   <= IDLE;
            sub     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            sub     <= sub_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
        end
    end
    always_comb begin
        state_n = state;
        sub_n   = sub;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: if (tick && !empty) begin
                pop     = 1'b1;
                shift_n = fifo_dout;
                state_n = START;
                sub_n   = '0;
            end
            START: if (tick) begin
                sub_n = sub + 4'd1;
                if (last) begin
                    state_n = DATA;
                    sub_n   = '0;
                    bit_n   = '0;
                end
            end
            DATA: if (tick) begin
                sub_n = sub + 4'd1;
                if (last) begin
                    sub_n   = '0;
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_n = STOP;
                        bit_n   = '0;
                    end
                end
            end
            STOP: if (tick) begin
                sub_n = sub + 4'd1;
                if (last) begin
                    sub_n   = '0;
                    pop     = ~empty;
                    shift_n = empty ? shift : fifo_dout;
                    state_n = empty ? IDLE : START;
                end
            end
            default: state_n = IDLE;
        endcase
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end
endmodule
